// File: rtl/fir_pkg.sv
// Shared definitions for the filter chain: width helpers, FSM states and
// the round/saturate arithmetic used by every stage's output.
`timescale 1ns/1ps
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_e;

    // Ceiling log2, with a minimum result of 1 so that the index buses never collapse to zero bits.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // The accumulator has enough headroom for TAPS full-scale products.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + clog2(taps);
    endfunction

    // Round half up by 'shift' bits, then clamp to an out_w-bit signed range when clamp_en is set.
    // The work is done at 64 bits so the rounding carry can never wrap.
    function automatic logic signed [63:0] round_sat(
        input  logic signed [63:0] value,
        input  int                 shift,
        input  int                 out_w,
        input  logic               clamp_en,
        output logic               clipped
    );
        logic signed [63:0] rounded;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        rounded = value;
        if (shift > 0) begin
            rounded = (value + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        max_v   = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (out_w - 1));
        clipped = 1'b0;
        if (clamp_en && (rounded > max_v)) begin
            rounded = max_v;
            clipped = 1'b1;
        end else if (clamp_en && (rounded < min_v)) begin
            rounded = min_v;
            clipped = 1'b1;
        end
        return rounded;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational output stage: rounds the accumulator by SHIFT bits and
// saturates to OUT_W bits. When the rounded value always fits, it is just
// sign-extended and the clip flag stays low.
`timescale 1ns/1ps
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int ACC_W = 28,
    parameter int SHIFT = 0,
    parameter int OUT_W = 28
) (
    input  logic signed [ACC_W-1:0] acc_in,
    output logic signed [OUT_W-1:0] data_out,
    output logic                    sat_out
);

    localparam bit CLAMP_EN = ((ACC_W - SHIFT) > OUT_W);

    logic signed [63:0] acc_ext;
    logic signed [63:0] result;
    logic               clipped;

    // Widen, round and clamp the accumulator in one combinational step.
    always_comb begin
        acc_ext  = 64'(acc_in);
        result   = round_sat(acc_ext, SHIFT, OUT_W, CLAMP_EN, clipped);
        data_out = OUT_W'(result);
        sat_out  = clipped;
    end

endmodule

// File: rtl/fir_decim_mac.sv
// Decimating FIR filter built around one time-multiplexed multiply-accumulate.
// Every DECIM-th accepted sample starts a TAPS-cycle MAC pass over the frozen
// delay line, followed by one cycle that registers the rounded, saturated result.
`timescale 1ns/1ps
module fir_decim_mac
    import fir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 9,
    parameter int TAPS   = 8,
    parameter int DECIM  = 4,
    parameter int SHIFT  = 0,
    parameter int OUT_W  = 28
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     coef_wr,
    input  logic [clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     coef_err,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid,
    output logic                     out_sat
);

    localparam int ADDR_W = clog2(TAPS);
    localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int PH_W   = clog2(DECIM);

    fir_state_e state_q, state_d;

    logic signed [DATA_W-1:0] x_q [TAPS];
    logic signed [DATA_W-1:0] x_d [TAPS];
    logic signed [COEF_W-1:0] c_q [TAPS];
    logic signed [COEF_W-1:0] c_d [TAPS];
    logic [PH_W-1:0]          phase_q, phase_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [ADDR_W-1:0]        tap_q, tap_d;
    logic signed [OUT_W-1:0]  out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_sat_q, out_sat_d;
    logic                     coef_err_q, coef_err_d;

    logic                     accept;
    logic                     phase_last;
    logic                     tap_last;
    logic                     addr_ok;
    logic signed [PROD_W-1:0] product;
    logic signed [OUT_W-1:0]  rs_data;
    logic                     rs_sat;

    assign accept     = in_valid && in_ready;
    assign phase_last = (phase_q == PH_W'(DECIM - 1));
    assign tap_last   = (tap_q == ADDR_W'(TAPS - 1));
    assign addr_ok    = ({1'b0, coef_addr} < (ADDR_W + 1)'(TAPS));

    fir_round_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .acc_in   (acc_q),
        .data_out (rs_data),
        .sat_out  (rs_sat)
    );

    // State register; reset drops any MAC in flight back to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a decimating accept starts a MAC pass, the last tap moves to OUT, OUT lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && phase_last) state_d = MAC;
            MAC:     if (tap_last) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: ready only while idle, everything else straight from registers.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_data  = out_data_q;
        out_valid = out_valid_q;
        out_sat   = out_sat_q;
        coef_err  = coef_err_q;
    end

    // Datapath next values: sample shift, coefficient load, MAC step and output capture.
    always_comb begin
        x_d         = x_q;
        c_d         = c_q;
        phase_d     = phase_q;
        acc_d       = acc_q;
        tap_d       = tap_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_sat_d   = 1'b0;
        coef_err_d  = 1'b0;
        product     = PROD_W'(x_q[tap_q]) * PROD_W'(c_q[tap_q]);

        if (accept) begin
            x_d[0] = in_data;
            for (int k = 1; k < TAPS; k++) begin
                x_d[k] = x_q[k-1];
            end
            if (phase_last) begin
                phase_d = '0;
                acc_d   = '0;
                tap_d   = '0;
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
        end

        if (coef_wr) begin
            if ((state_q == IDLE) && addr_ok) begin
                c_d[coef_addr] = coef_data;
            end else begin
                coef_err_d = 1'b1;
            end
        end

        if (state_q == MAC) begin
            acc_d = acc_q + ACC_W'(product);
            if (!tap_last) begin
                tap_d = tap_q + ADDR_W'(1);
            end
        end

        if (state_q == OUT) begin
            out_data_d  = rs_data;
            out_valid_d = 1'b1;
            out_sat_d   = rs_sat;
        end
    end

    // Datapath registers with asynchronous clear of delay line, coefficients and outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
                c_q[k] <= '0;
            end
            phase_q     <= '0;
            acc_q       <= '0;
            tap_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
            coef_err_q  <= 1'b0;
        end else begin
            x_q         <= x_d;
            c_q         <= c_d;
            phase_q     <= phase_d;
            acc_q       <= acc_d;
            tap_q       <= tap_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sat_q   <= out_sat_d;
            coef_err_q  <= coef_err_d;
        end
    end

endmodule

// File: tb/tb_fir_decim_mac.sv
// Testbench for fir_decim_mac. Four instances with different parameter sets
// share one input bus; 'sel' steers in_valid/coef_wr to one of them. Expected
// outputs come from a convolution model over the accepted-sample history.
`timescale 1ns/1ps
module tb_fir_decim_mac;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic signed [15:0]  in_data;
    logic                in_valid;
    logic                coef_wr;
    logic [2:0]          coef_addr;
    logic signed [8:0]   coef_data;
    int                  sel;

    logic [N-1:0]        iv, cw, rdy, cerr, ov, os;
    logic signed [27:0]  od0, od1, od3;
    logic signed [15:0]  od2;

    int taps_p  [N] = '{8, 6, 8, 8};
    int decim_p [N] = '{4, 1, 4, 1};
    int shift_p [N] = '{0, 0, 0, 4};
    int outw_p  [N] = '{28, 28, 16, 28};
    int accw_p  [N] = '{28, 28, 28, 28};

    longint hist [N][$];
    longint cm   [N][8];
    int     cnt  [N];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < N; g++) begin : g_en
        assign iv[g] = in_valid && (sel == g);
        assign cw[g] = coef_wr && (sel == g);
    end

    fir_decim_mac #(.DATA_W(16), .COEF_W(9), .TAPS(8), .DECIM(4), .SHIFT(0), .OUT_W(28)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(iv[0]), .in_ready(rdy[0]),
        .coef_wr(cw[0]), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(cerr[0]),
        .out_data(od0), .out_valid(ov[0]), .out_sat(os[0]));

    fir_decim_mac #(.DATA_W(16), .COEF_W(9), .TAPS(6), .DECIM(1), .SHIFT(0), .OUT_W(28)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(iv[1]), .in_ready(rdy[1]),
        .coef_wr(cw[1]), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(cerr[1]),
        .out_data(od1), .out_valid(ov[1]), .out_sat(os[1]));

    fir_decim_mac #(.DATA_W(16), .COEF_W(9), .TAPS(8), .DECIM(4), .SHIFT(0), .OUT_W(16)) dut2 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(iv[2]), .in_ready(rdy[2]),
        .coef_wr(cw[2]), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(cerr[2]),
        .out_data(od2), .out_valid(ov[2]), .out_sat(os[2]));

    fir_decim_mac #(.DATA_W(16), .COEF_W(9), .TAPS(8), .DECIM(1), .SHIFT(4), .OUT_W(28)) dut3 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(iv[3]), .in_ready(rdy[3]),
        .coef_wr(cw[3]), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(cerr[3]),
        .out_data(od3), .out_valid(ov[3]), .out_sat(os[3]));

    function automatic logic signed [63:0] obs_data(input int s);
        case (s)
            0:       return 64'(od0);
            1:       return 64'(od1);
            2:       return 64'(od2);
            default: return 64'(od3);
        endcase
    endfunction

    // Reference model: clear history, coefficients and sample counts.
    task automatic model_reset();
        for (int s = 0; s < N; s++) begin
            hist[s].delete();
            cnt[s] = 0;
            for (int k = 0; k < 8; k++) cm[s][k] = 0;
        end
    endtask

    // Reference model: y = sum c[k]*x[n-k], round half up, clamp when the range can overflow.
    task automatic model_accept(input int s, input longint v, output bit emit,
                                output longint exp_d, output bit exp_s);
        longint sum, r, div, maxv, minv;
        hist[s].push_front(v);
        if (hist[s].size() > taps_p[s]) hist[s].delete(hist[s].size() - 1);
        cnt[s]++;
        emit = ((cnt[s] % decim_p[s]) == 0);
        sum = 0;
        for (int k = 0; k < hist[s].size(); k++) sum += cm[s][k] * hist[s][k];
        r = sum;
        if (shift_p[s] > 0) begin
            div = longint'(1) << shift_p[s];
            r = sum + div / 2;
            if ((r < 0) && ((r % div) != 0)) r = r / div - 1;
            else r = r / div;
        end
        exp_s = 1'b0;
        if ((accw_p[s] - shift_p[s]) > outw_p[s]) begin
            maxv = (longint'(1) << (outw_p[s] - 1)) - 1;
            minv = -(longint'(1) << (outw_p[s] - 1));
            if (r > maxv) begin r = maxv; exp_s = 1'b1; end
            else if (r < minv) begin r = minv; exp_s = 1'b1; end
        end
        exp_d = r;
    endtask

    task automatic send(input int s, input logic signed [15:0] v, input bit wr,
                        input int addr, input logic signed [8:0] cval);
        int n;
        @(negedge clk);
        sel = s; in_data = v; in_valid = 1'b1;
        coef_wr = wr; coef_addr = 3'(addr); coef_data = cval;
        n = 0;
        while ((rdy[s] !== 1'b1) && (n < 50)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("[TB] FAIL send_timeout: in_ready low for %0d cycles, required high within 50", n);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; coef_wr = 1'b0;
    endtask

    task automatic wait_out(input int s, output bit got, output logic signed [63:0] d,
                            output logic sat, output int lat);
        got = 1'b0; d = '0; sat = 1'b0; lat = 0;
        for (int n = 1; (n <= 40) && !got; n++) begin
            @(negedge clk);
            if (ov[s] === 1'b1) begin
                got = 1'b1; d = obs_data(s); sat = os[s]; lat = n;
            end
        end
    endtask

    task automatic write_coef(input int s, input int addr, input logic signed [8:0] val, output logic err);
        @(negedge clk);
        sel = s; coef_wr = 1'b1; coef_addr = 3'(addr); coef_data = val;
        @(posedge clk); #1;
        coef_wr = 1'b0;
        @(negedge clk);
        err = cerr[s];
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; coef_wr = 1'b0; in_data = '0;
        coef_addr = '0; coef_data = '0; sel = 0;
        #2 reset = 1'b0;
        #10;
        for (int s = 0; s < N; s++) begin
            checks++; if (rdy[s] !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready[%0d]: got %b required 1", s, rdy[s]); end
            checks++; if (ov[s] !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid[%0d]: got %b required 0", s, ov[s]); end
            checks++; if (os[s] !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_sat[%0d]: got %b required 0", s, os[s]); end
            checks++; if (cerr[s] !== 1'b0) begin errors++; $display("[TB] FAIL reset_coef_err[%0d]: got %b required 0", s, cerr[s]); end
            checks++; if (obs_data(s) !== 64'sd0) begin errors++; $display("[TB] FAIL reset_out_data[%0d]: got %0d required 0", s, obs_data(s)); end
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_impulse();
        logic err; bit emit, got; longint ed; bit es; logic signed [63:0] od; logic osat; int lat; int nout;
        longint lit [2] = '{4000, 8000};
        for (int k = 0; k < 8; k++) begin
            write_coef(0, k, 9'(k + 1), err);
            cm[0][k] = k + 1;
            checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL impulse_coef_err: got %b required 0", err); end
        end
        nout = 0;
        for (int i = 0; i < 8; i++) begin
            logic signed [15:0] v;
            v = (i == 0) ? 16'sd1000 : 16'sd0;
            model_accept(0, longint'(v), emit, ed, es);
            send(0, v, 1'b0, 0, '0);
            if (emit) begin
                wait_out(0, got, od, osat, lat);
                checks++;
                if (!got || (od !== 64'(lit[nout])) || (od !== 64'(ed)) || (osat !== 1'b0)) begin
                    errors++;
                    $display("[TB] FAIL impulse_out: got valid=%0d data=%0d sat=%0d required data=%0d sat=0", got, od, osat, lit[nout]);
                end
                checks++;
                if (lat !== 10) begin errors++; $display("[TB] FAIL impulse_latency: got %0d required 10", lat); end
                nout++;
            end
        end
    endtask

    task automatic test_dc();
        logic err; bit emit, got; longint ed; bit es; logic signed [63:0] od; logic osat; int lat; int nout; int low;
        for (int k = 0; k < 8; k++) begin
            write_coef(0, k, 9'sd1, err);
            cm[0][k] = 1;
        end
        nout = 0;
        for (int i = 0; i < 12; i++) begin
            model_accept(0, 100, emit, ed, es);
            send(0, 16'sd100, 1'b0, 0, '0);
            if (emit) begin
                got = 1'b0; od = '0; osat = 1'b0; low = 0;
                for (int n = 0; n < 40; n++) begin
                    @(negedge clk);
                    if (ov[0] === 1'b1) begin got = 1'b1; od = obs_data(0); osat = os[0]; end
                    if (rdy[0] === 1'b1) break;
                    low++;
                end
                checks++;
                if (low !== 9) begin errors++; $display("[TB] FAIL dc_ready_low: got %0d cycles required 9", low); end
                checks++;
                if (!got || (od !== 64'(ed)) || (osat !== 1'b0) || ((nout > 0) && (od !== 64'sd800))) begin
                    errors++;
                    $display("[TB] FAIL dc_out: got valid=%0d data=%0d sat=%0d required data=%0d sat=0", got, od, osat, ed);
                end
                nout++;
            end
        end
    endtask

    task automatic test_sign_and_addr();
        logic err; bit emit, got; longint ed; bit es; logic signed [63:0] od; logic osat; int lat;
        longint lit [2] = '{32768, -5};
        logic signed [15:0] vin [2] = '{-16'sd32768, 16'sd5};
        for (int a = 6; a < 8; a++) begin
            write_coef(1, a, 9'sd77, err);
            checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL addr_coef_err[%0d]: got %b required 1", a, err); end
            @(negedge clk);
            checks++; if (cerr[1] !== 1'b0) begin errors++; $display("[TB] FAIL addr_coef_err_pulse[%0d]: got %b required 0", a, cerr[1]); end
        end
        for (int i = 0; i < 2; i++) begin
            if (i == 0) cm[1][0] = -1;
            model_accept(1, longint'(vin[i]), emit, ed, es);
            send(1, vin[i], (i == 0), 0, -9'sd1);
            wait_out(1, got, od, osat, lat);
            checks++;
            if (!got || (od !== 64'(lit[i])) || (od !== 64'(ed)) || (osat !== 1'b0)) begin
                errors++;
                $display("[TB] FAIL sign_out: got valid=%0d data=%0d sat=%0d required data=%0d sat=0", got, od, osat, lit[i]);
            end
        end
    endtask

    task automatic test_saturate();
        logic err; bit emit, got; longint ed; bit es; logic signed [63:0] od; logic osat; int lat;
        for (int k = 0; k < 8; k++) begin
            write_coef(2, k, 9'sd255, err);
            cm[2][k] = 255;
        end
        for (int i = 0; i < 16; i++) begin
            logic signed [15:0] v;
            v = (i < 8) ? 16'sd32767 : -16'sd32768;
            model_accept(2, longint'(v), emit, ed, es);
            send(2, v, 1'b0, 0, '0);
            if (emit) begin
                wait_out(2, got, od, osat, lat);
                checks++;
                if (!got || (od !== 64'(ed)) || (osat !== es) || ((i == 7) && ((od !== 64'sd32767) || (osat !== 1'b1)))) begin
                    errors++;
                    $display("[TB] FAIL sat_out: got valid=%0d data=%0d sat=%0d required data=%0d sat=%0d", got, od, osat, ed, es);
                end
            end
        end
    endtask

    task automatic test_round();
        logic err; bit emit, got; longint ed; bit es; logic signed [63:0] od; logic osat; int lat;
        logic signed [15:0] vin [6] = '{16'sd24, -16'sd24, 16'sd8, 16'sd7, -16'sd8, -16'sd9};
        write_coef(3, 0, 9'sd1, err);
        cm[3][0] = 1;
        for (int i = 0; i < 6; i++) begin
            model_accept(3, longint'(vin[i]), emit, ed, es);
            send(3, vin[i], 1'b0, 0, '0);
            wait_out(3, got, od, osat, lat);
            checks++;
            if (!got || (od !== 64'(ed)) || (osat !== 1'b0) || ((i == 0) && (od !== 64'sd2)) || ((i == 1) && (od !== -64'sd1))) begin
                errors++;
                $display("[TB] FAIL round_out[%0d]: got valid=%0d data=%0d sat=%0d required data=%0d sat=0", vin[i], got, od, osat, ed);
            end
        end
    endtask

    task automatic test_busy();
        logic err; bit emit, got; longint ed; bit es; logic signed [63:0] od; logic osat; int lat; int n;
        logic signed [15:0] v, d2;
        logic signed [8:0] newc;
        for (int k = 0; k < 8; k++) begin
            logic signed [8:0] cv;
            cv = 9'($urandom);
            write_coef(0, k, cv, err);
            cm[0][k] = longint'(cv);
        end
        while ((cnt[0] % 4) != 3) begin
            v = 16'($urandom);
            model_accept(0, longint'(v), emit, ed, es);
            send(0, v, 1'b0, 0, '0);
        end
        v  = 16'($urandom);
        d2 = 16'($urandom) | 16'sd1;
        newc = (cm[0][0] == 100) ? -9'sd100 : 9'sd100;
        model_accept(0, longint'(v), emit, ed, es);
        send(0, v, 1'b0, 0, '0);
        @(negedge clk);
        in_data = d2; in_valid = 1'b1; coef_wr = 1'b1; coef_addr = 3'd0; coef_data = newc;
        @(posedge clk); #1;
        coef_wr = 1'b0;
        @(negedge clk);
        checks++; if (cerr[0] !== 1'b1) begin errors++; $display("[TB] FAIL busy_coef_err: got %b required 1", cerr[0]); end
        @(negedge clk);
        checks++; if (cerr[0] !== 1'b0) begin errors++; $display("[TB] FAIL busy_coef_err_pulse: got %b required 0", cerr[0]); end
        n = 0;
        while ((rdy[0] !== 1'b1) && (n < 40)) begin
            @(negedge clk);
            n++;
        end
        got = ov[0]; od = obs_data(0); osat = os[0];
        checks++;
        if ((got !== 1'b1) || (od !== 64'(ed)) || (osat !== es)) begin
            errors++;
            $display("[TB] FAIL busy_out: got valid=%0d data=%0d sat=%0d required data=%0d sat=%0d", got, od, osat, ed, es);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_accept(0, longint'(d2), emit, ed, es);
        for (int i = 0; i < 3; i++) begin
            v = 16'($urandom);
            model_accept(0, longint'(v), emit, ed, es);
            send(0, v, 1'b0, 0, '0);
        end
        wait_out(0, got, od, osat, lat);
        checks++;
        if (!got || (od !== 64'(ed)) || (osat !== es)) begin
            errors++;
            $display("[TB] FAIL busy_after_out: got valid=%0d data=%0d sat=%0d required data=%0d sat=%0d", got, od, osat, ed, es);
        end
    endtask

    task automatic test_random();
        logic err; bit emit, got; longint ed; bit es; logic signed [63:0] od; logic osat; int lat;
        logic signed [15:0] v;
        for (int s = 0; s < N; s++) begin
            for (int k = 0; k < taps_p[s]; k++) begin
                logic signed [8:0] cv;
                cv = 9'($urandom);
                write_coef(s, k, cv, err);
                cm[s][k] = longint'(cv);
            end
            for (int i = 0; i < 8; i++) begin
                v = 16'($urandom);
                model_accept(s, longint'(v), emit, ed, es);
                send(s, v, 1'b0, 0, '0);
                if (emit) begin
                    wait_out(s, got, od, osat, lat);
                    checks++;
                    if (!got || (od !== 64'(ed)) || (osat !== es) || (lat !== taps_p[s] + 2)) begin
                        errors++;
                        $display("[TB] FAIL random_out[%0d]: got valid=%0d data=%0d sat=%0d lat=%0d required data=%0d sat=%0d lat=%0d",
                                 s, got, od, osat, lat, ed, es, taps_p[s] + 2);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_mac();
        bit emit, got; longint ed; bit es; logic signed [63:0] od; logic osat; int lat;
        bit bad_v, bad_d, bad_r;
        logic signed [15:0] v;
        while ((cnt[0] % 4) != 3) begin
            v = 16'($urandom);
            model_accept(0, longint'(v), emit, ed, es);
            send(0, v, 1'b0, 0, '0);
        end
        send(0, 16'sd1234, 1'b0, 0, '0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        bad_v = 1'b0; bad_d = 1'b0; bad_r = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (ov[0] !== 1'b0) bad_v = 1'b1;
            if (obs_data(0) !== 64'sd0) bad_d = 1'b1;
            if (rdy[0] !== 1'b1) bad_r = 1'b1;
        end
        checks++; if (bad_v) begin errors++; $display("[TB] FAIL abort_out_valid: got 1 required 0"); end
        checks++; if (bad_d) begin errors++; $display("[TB] FAIL abort_out_data: got nonzero required 0"); end
        checks++; if (bad_r) begin errors++; $display("[TB] FAIL abort_in_ready: got 0 required 1"); end
        for (int i = 0; i < 4; i++) begin
            v = (i == 0) ? 16'sd1000 : 16'sd0;
            model_accept(0, longint'(v), emit, ed, es);
            send(0, v, 1'b0, 0, '0);
            if (emit) begin
                wait_out(0, got, od, osat, lat);
                checks++;
                if (!got || (od !== 64'sd0) || (od !== 64'(ed)) || (osat !== 1'b0)) begin
                    errors++;
                    $display("[TB] FAIL post_reset_out: got valid=%0d data=%0d sat=%0d required data=0 sat=0", got, od, osat);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_sign_and_addr();
        test_saturate();
        test_round();
        test_busy();
        test_random();
        test_reset_mid_mac();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
